gen_mux_rr: RTL and testbench

- Registered, handshaked N-to-1 channel multiplexer: the sequential successor of the combinational generic mux.
- Selects one of 2**SEL input channels, either by an explicit select (fixed mode) or by round-robin arbitration.
- Holds a grant for a whole packet, delimited by a per-channel last flag.
- Drives one registered valid/ready output stage. Sits between multiple HDR frame/word sources and a single downstream consumer, e.g. the serializer.

---
 rtl/gen_mux_rr_if.sv | 31 +++
 rtl/gen_mux_rr.sv | 119 +++++++++++
 tb/tb_gen_mux_rr.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gen_mux_rr_if.sv
// Channel-side and consumer-side signals of the round-robin channel mux.
// The slave modport is the mux's view; the master modport is the environment's view.
interface gen_mux_rr_if #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned SEL       = 3
);
  localparam int unsigned N = 2 ** SEL;

  logic [BUS_WIDTH*N-1:0] i_data_in;
  logic [N-1:0]           i_valid;
  logic [N-1:0]           i_last;
  logic [N-1:0]           o_ready;
  logic                   i_mode;
  logic [SEL-1:0]         i_ctrl_sel;
  logic [BUS_WIDTH-1:0]   o_data;
  logic                   o_valid;
  logic                   o_last;
  logic [SEL-1:0]         o_sel;
  logic                   i_ready;
  logic                   o_busy;

  modport slave (
    input  i_data_in, i_valid, i_last, i_mode, i_ctrl_sel, i_ready,
    output o_ready, o_data, o_valid, o_last, o_sel, o_busy
  );

  modport master (
    output i_data_in, i_valid, i_last, i_mode, i_ctrl_sel, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_sel, o_busy
  );
endinterface

// File: rtl/gen_mux_rr.sv
// Registered N-to-1 channel mux with fixed or round-robin selection. A grant is held
// for a whole packet (until the granted channel's last beat) and feeds one
// registered valid/ready output stage.
module gen_mux_rr #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned SEL       = 3
) (
  input logic         i_sys_clk,
  input logic         i_sys_rst_n,
  gen_mux_rr_if.slave bus
);
  localparam int unsigned N = 2 ** SEL;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state_q;
  logic [SEL-1:0]       lock_ch_q;
  logic [SEL-1:0]       ptr_q;
  logic [BUS_WIDTH-1:0] data_q;
  logic                 valid_q;
  logic                 last_q;
  logic [SEL-1:0]       sel_q;

  logic                 rr_found;
  logic [SEL-1:0]       rr_ch;
  logic [SEL-1:0]       idx;
  logic                 gnt_vld;
  logic [SEL-1:0]       gnt;
  logic                 le;
  logic                 xfer;
  logic                 gnt_last;
  logic [BUS_WIDTH-1:0] gnt_data;

  // Round-robin search: first valid channel starting at ptr, wrapping modulo N.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    idx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr_q + SEL'(i);
      if (!rr_found && bus.i_valid[idx]) begin
        rr_found = 1'b1;
        rr_ch    = idx;
      end
    end
  end

  // Grant selection, load enable and transfer detection.
  always_comb begin
    if (state_q == ST_LOCKED) begin
      gnt_vld = 1'b1;
      gnt     = lock_ch_q;
    end else if (!bus.i_mode) begin
      gnt_vld = 1'b1;
      gnt     = bus.i_ctrl_sel;
    end else begin
      gnt_vld = rr_found;
      gnt     = rr_ch;
    end
    le       = !valid_q || bus.i_ready;
    xfer     = gnt_vld && le && bus.i_valid[gnt];
    gnt_last = bus.i_last[gnt];
    gnt_data = bus.i_data_in[gnt*BUS_WIDTH +: BUS_WIDTH];
  end

  // Per-channel ready: only the granted channel, and never while reset is asserted.
  always_comb begin
    bus.o_ready = '0;
    if (gnt_vld && le && i_sys_rst_n) begin
      bus.o_ready[gnt] = 1'b1;
    end
  end

  // Output register: load on transfer, drain valid when empty-loading, hold on stall.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sel_q   <= '0;
    end else if (le) begin
      if (xfer) begin
        data_q  <= gnt_data;
        valid_q <= 1'b1;
        last_q  <= gnt_last;
        sel_q   <= gnt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // Packet lock FSM and round-robin pointer, both advanced only by transfers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= '0;
      ptr_q     <= '0;
    end else if (xfer) begin
      if (state_q == ST_IDLE && !gnt_last) begin
        state_q   <= ST_LOCKED;
        lock_ch_q <= gnt;
      end else if (state_q == ST_LOCKED && gnt_last) begin
        state_q <= ST_IDLE;
      end
      if (gnt_last) begin
        ptr_q <= gnt + SEL'(1);
      end
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_busy  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_gen_mux_rr.sv
// Directed bench for gen_mux_rr: fixed mode, round-robin order and wrap, packet lock,
// backpressure and mid-packet reset, with hand-computed expectations.
module tb_gen_mux_rr;
  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  gen_mux_rr_if #(.BUS_WIDTH(8), .SEL(3)) bus ();

  gen_mux_rr #(.BUS_WIDTH(8), .SEL(3)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [7:0] d, input logic l);
    bus.i_data_in[k*8 +: 8] = d;
    bus.i_last[k]           = l;
    bus.i_valid[k]          = 1'b1;
  endtask

  task automatic clr(input int k);
    bus.i_valid[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    passed         = 0;
    total          = 0;
    rst_n          = 1'b0;
    bus.i_data_in  = '0;
    bus.i_valid    = '0;
    bus.i_last     = '0;
    bus.i_mode     = 1'b0;
    bus.i_ctrl_sel = 3'd2;
    bus.i_ready    = 1'b1;

    // Reset state; a valid selected channel must still see no ready.
    drive(2, 8'h11, 1'b0);
    #2;
    chk("rst_data", 32'(bus.o_data), 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_last", 32'(bus.o_last), 32'h0);
    chk("rst_sel", 32'(bus.o_sel), 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    chk("rst_ready", 32'(bus.o_ready), 32'h0);

    // Fixed mode, ch2 three-beat packet.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fix_ready", 32'(bus.o_ready), 32'h04);
    tick();
    chk("fix_d0", 32'(bus.o_data), 32'h11);
    chk("fix_v0", 32'(bus.o_valid), 32'h1);
    chk("fix_s0", 32'(bus.o_sel), 32'h2);
    chk("fix_b0", 32'(bus.o_busy), 32'h1);
    chk("fix_l0", 32'(bus.o_last), 32'h0);
    drive(2, 8'h22, 1'b0);
    tick();
    chk("fix_d1", 32'(bus.o_data), 32'h22);
    chk("fix_b1", 32'(bus.o_busy), 32'h1);
    drive(2, 8'h33, 1'b1);
    tick();
    chk("fix_d2", 32'(bus.o_data), 32'h33);
    chk("fix_l2", 32'(bus.o_last), 32'h1);
    chk("fix_b2", 32'(bus.o_busy), 32'h0);
    clr(2);
    tick();
    chk("fix_drain_v", 32'(bus.o_valid), 32'h0);
    chk("fix_hold_d", 32'(bus.o_data), 32'h33);

    // Round-robin order 0,3,5 from ptr 0.
    do_reset();
    bus.i_mode = 1'b1;
    drive(0, 8'hA0, 1'b1);
    drive(3, 8'hA3, 1'b1);
    drive(5, 8'hA5, 1'b1);
    #1;
    chk("rr_rdy0", 32'(bus.o_ready), 32'h01);
    tick();
    chk("rr_sel0", 32'(bus.o_sel), 32'h0);
    chk("rr_d0", 32'(bus.o_data), 32'hA0);
    clr(0);
    #1;
    chk("rr_rdy3", 32'(bus.o_ready), 32'h08);
    tick();
    chk("rr_sel3", 32'(bus.o_sel), 32'h3);
    clr(3);
    #1;
    chk("rr_rdy5", 32'(bus.o_ready), 32'h20);
    tick();
    chk("rr_sel5", 32'(bus.o_sel), 32'h5);
    clr(5);
    // ptr must now be 6: with ch0, ch5, ch6 valid, ch6 wins.
    drive(0, 8'hB0, 1'b1);
    drive(5, 8'hB5, 1'b1);
    drive(6, 8'hE6, 1'b1);
    #1;
    chk("rr_ptr6", 32'(bus.o_ready), 32'h40);
    tick();
    chk("rr_sel6", 32'(bus.o_sel), 32'h6);
    clr(0);
    clr(5);
    clr(6);

    // Wrap: ptr 7 with ch7 and ch1 valid.
    drive(7, 8'hF7, 1'b1);
    drive(1, 8'hF1, 1'b1);
    #1;
    chk("wrap_rdy7", 32'(bus.o_ready), 32'h80);
    tick();
    chk("wrap_sel7", 32'(bus.o_sel), 32'h7);
    clr(7);
    #1;
    chk("wrap_rdy1", 32'(bus.o_ready), 32'h02);
    tick();
    chk("wrap_d1", 32'(bus.o_data), 32'hF1);
    clr(1);

    // Lock under competition: ch1 four beats, ch0 contends, mode toggles.
    drive(1, 8'hB1, 1'b0);
    #1;
    chk("lk_rdy", 32'(bus.o_ready), 32'h02);
    tick();
    chk("lk_d1", 32'(bus.o_data), 32'hB1);
    chk("lk_busy", 32'(bus.o_busy), 32'h1);
    drive(0, 8'hC0, 1'b1);
    drive(1, 8'hB2, 1'b0);
    bus.i_mode     = 1'b0;
    bus.i_ctrl_sel = 3'd0;
    #1;
    chk("lk_hold_rdy", 32'(bus.o_ready), 32'h02);
    tick();
    chk("lk_d2", 32'(bus.o_data), 32'hB2);
    chk("lk_s2", 32'(bus.o_sel), 32'h1);
    drive(1, 8'hB3, 1'b0);
    bus.i_mode = 1'b1;
    tick();
    chk("lk_d3", 32'(bus.o_data), 32'hB3);
    drive(1, 8'hB4, 1'b1);
    #1;
    chk("lk_rdy4", 32'(bus.o_ready), 32'h02);
    tick();
    chk("lk_d4", 32'(bus.o_data), 32'hB4);
    chk("lk_l4", 32'(bus.o_last), 32'h1);
    chk("lk_unbusy", 32'(bus.o_busy), 32'h0);
    clr(1);
    #1;
    chk("lk_ch0_rdy", 32'(bus.o_ready), 32'h01);
    tick();
    chk("lk_ch0_d", 32'(bus.o_data), 32'hC0);
    chk("lk_ch0_s", 32'(bus.o_sel), 32'h0);
    clr(0);

    // Backpressure on 0xA5 from ch3, next word 0x5A waiting.
    drive(3, 8'hA5, 1'b1);
    tick();
    chk("bp_d", 32'(bus.o_data), 32'hA5);
    drive(3, 8'h5A, 1'b1);
    bus.i_ready = 1'b0;
    #1;
    chk("bp_rdy", 32'(bus.o_ready), 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_d", 32'(bus.o_data), 32'hA5);
      chk("bp_stall_s", 32'(bus.o_sel), 32'h3);
      chk("bp_stall_l", 32'(bus.o_last), 32'h1);
      chk("bp_stall_v", 32'(bus.o_valid), 32'h1);
      chk("bp_stall_r", 32'(bus.o_ready), 32'h00);
    end
    bus.i_ready = 1'b1;
    #1;
    chk("bp_resume_rdy", 32'(bus.o_ready), 32'h08);
    tick();
    chk("bp_next_d", 32'(bus.o_data), 32'h5A);
    chk("bp_next_v", 32'(bus.o_valid), 32'h1);
    clr(3);
    tick();
    chk("bp_drain_v", 32'(bus.o_valid), 32'h0);

    // Mid-packet reset while locked on ch4.
    bus.i_mode     = 1'b0;
    bus.i_ctrl_sel = 3'd4;
    drive(4, 8'hD1, 1'b0);
    tick();
    chk("mr_d1", 32'(bus.o_data), 32'hD1);
    chk("mr_busy", 32'(bus.o_busy), 32'h1);
    drive(4, 8'hD2, 1'b0);
    tick();
    chk("mr_d2", 32'(bus.o_data), 32'hD2);
    rst_n = 1'b0;
    #1;
    chk("mr_data", 32'(bus.o_data), 32'h0);
    chk("mr_valid", 32'(bus.o_valid), 32'h0);
    chk("mr_sel", 32'(bus.o_sel), 32'h0);
    chk("mr_last", 32'(bus.o_last), 32'h0);
    chk("mr_busy0", 32'(bus.o_busy), 32'h0);
    chk("mr_ready", 32'(bus.o_ready), 32'h00);
    #1;
    rst_n      = 1'b1;
    bus.i_mode = 1'b1;
    drive(2, 8'hC2, 1'b1);
    #1;
    chk("mr_rr_rdy", 32'(bus.o_ready), 32'h04);
    tick();
    chk("mr_rr_sel", 32'(bus.o_sel), 32'h2);
    chk("mr_rr_d", 32'(bus.o_data), 32'hC2);
    chk("mr_rr_busy", 32'(bus.o_busy), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
